qoi_stream_framer: RTL
======================

QOI_STREAM_FRAMER -- requirements
Module: qoi_stream_framer

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  in  1  single-cycle request to begin one image.
REQ-005 SHALL have port: width  in  32  image width, sampled on accepted start.
REQ-006 SHALL have port: height  in  32  image height, sampled on accepted start.
REQ-007 SHALL have port: channels  in  8  header channels byte (3 or 4), sampled on accepted start.
REQ-008 SHALL have port: colorspace  in  8  header colorspace byte, sampled on accepted start.
REQ-009 SHALL have port: in_data  in  8  encoded chunk byte from upstream encoder.
REQ-010 SHALL have port: in_valid  in  1  in_data valid.
REQ-011 SHALL have port: in_last  in  1  marks final encoded byte of the image; qualified by in_valid.
REQ-012 SHALL have port: in_ready  out  1  framer accepts in_data this cycle.
REQ-013 SHALL have port: out_data  out  8  framed QOI stream byte (FIFO head).
REQ-014 SHALL have port: out_valid  out  1  out_data valid (FIFO non-empty).
REQ-015 SHALL have port: out_ready  in  1  downstream consumes out_data this cycle.
REQ-016 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port: done  out  1  one-cycle pulse when image fully drained.
REQ-018 SHALL have port: byte_count  out  32  bytes popped from output since last accepted start.

Function
REQ-019 SHALL implement states IDLE, HEADER, BODY, FOOTER, FLUSH.
REQ-020 IDLE: start=1 latches width/height/channels/colorspace, clears byte_count, next state HEADER; start while not IDLE SHALL be ignored.
REQ-021 HEADER: SHALL push 14 bytes, one per cycle FIFO not full: 71 6F 69 66, width big-endian (4), height big-endian (4), channels, colorspace; after 14th push -> BODY.
REQ-022 BODY: in_ready = !fifo_full; handshake in_valid&&in_ready pushes in_data unmodified; handshake with in_last=1 -> FOOTER.
REQ-023 in_ready SHALL be 0 in all states other than BODY; input in other states is not consumed.
REQ-024 FOOTER: SHALL push 00 00 00 00 00 00 00 01, one per cycle FIFO not full; after 8th push -> FLUSH.
REQ-025 FLUSH: when FIFO empty, done=1 for exactly that cycle and next state IDLE.
REQ-026 FIFO: out_valid = count!=0; pop on out_valid&&out_ready; push blocked when count==FIFO_DEPTH; simultaneous push and pop SHALL leave count unchanged and preserve order; pointers wrap modulo FIFO_DEPTH.
REQ-027 Full decision SHALL use registered count (a pop in the same cycle does not unblock a push).
REQ-028 Latency: start sampled at edge N -> first header byte pushed at edge N+1 -> out_valid=1 after edge N+1; in->out minimum latency 1 cycle.
REQ-029 byte_count SHALL increment by 1 per pop, wrapping at 2^32.
REQ-030 Zero-length body (in_last on first BODY byte) SHALL still emit that byte then footer.

Reset
REQ-031 rst SHALL force: state IDLE, FIFO empty, out_valid=0, in_ready=0, busy=0, done=0, byte_count=0, latched header fields 0.
REQ-032 rst mid-image SHALL discard all FIFO contents and partial header/footer progress; the next image starts clean from start.

Configuration
REQ-033 Macro QOI_FRAMER_BYTECOUNT_EN: defined -> byte_count implemented per REQ-029; undefined -> counter not built, byte_count tied to 0; all other behaviour identical.

Verification
REQ-034 rst, start with width=0x00000010, height=0x00000008, channels=4, colorspace=0, out_ready=1 -> out 71 6F 69 66 00 00 00 10 00 00 00 08 04 00 in order, in_ready=0 throughout header.
REQ-035 Body 3 bytes FE 12 34 (last on 34), out_ready=1 -> out FE 12 34 then 00x7 01, done pulses once, byte_count=25 (with macro), busy falls with done.
REQ-036 out_ready=0 during BODY with in_valid=1 -> exactly FIFO_DEPTH=4 bytes accepted, in_ready=0 afterward; release out_ready -> no byte lost or duplicated.
REQ-037 FIFO full with out_ready=1 and in_valid=1 each cycle -> one byte out per cycle, push resumes one cycle after pop, order preserved.
REQ-038 rst asserted after 5th header byte popped -> out_valid=0 next cycle, busy=0; new start emits full 14-byte header from 71.
REQ-039 start pulsed again during BODY -> ignored; header fields and byte_count unchanged.

Source files
------------

// File: rtl/qoi_stream_framer.sv
// QOI stream framer: wraps an encoded chunk byte stream with the 14-byte QOI header and 8-byte
// end marker through a small output FIFO. Define QOI_FRAMER_BYTECOUNT_EN to build byte_count.
module qoi_stream_framer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] width,
    input  logic [31:0] height,
    input  logic [7:0]  channels,
    input  logic [7:0]  colorspace,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] byte_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_BODY   = 3'd2;
    localparam logic [2:0] ST_FOOTER = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;

    logic [2:0]    state;
    logic [3:0]    idx;
    logic [31:0]   width_q;
    logic [31:0]   height_q;
    logic [7:0]    channels_q;
    logic [7:0]    colorspace_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic [7:0]    hdr_byte;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign in_ready  = (state == ST_BODY) && !fifo_full;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FLUSH) && (count == '0);

    always_comb begin
        hdr_byte = colorspace_q;
        case (idx)
            4'd0:    hdr_byte = 8'h71;
            4'd1:    hdr_byte = 8'h6F;
            4'd2:    hdr_byte = 8'h69;
            4'd3:    hdr_byte = 8'h66;
            4'd4:    hdr_byte = width_q[31:24];
            4'd5:    hdr_byte = width_q[23:16];
            4'd6:    hdr_byte = width_q[15:8];
            4'd7:    hdr_byte = width_q[7:0];
            4'd8:    hdr_byte = height_q[31:24];
            4'd9:    hdr_byte = height_q[23:16];
            4'd10:   hdr_byte = height_q[15:8];
            4'd11:   hdr_byte = height_q[7:0];
            4'd12:   hdr_byte = channels_q;
            default: hdr_byte = colorspace_q;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        case (state)
            ST_HEADER: begin
                push      = !fifo_full;
                push_data = hdr_byte;
            end
            ST_BODY: begin
                push      = in_valid && !fifo_full;
                push_data = in_data;
            end
            ST_FOOTER: begin
                push      = !fifo_full;
                push_data = (idx == 4'd7) ? 8'h01 : 8'h00;
            end
            default: begin
                push      = 1'b0;
                push_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            width_q      <= '0;
            height_q     <= '0;
            channels_q   <= '0;
            colorspace_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        width_q      <= width;
                        height_q     <= height;
                        channels_q   <= channels;
                        colorspace_q <= colorspace;
                        idx          <= '0;
                        state        <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (push) begin
                        if (idx == 4'd13) begin
                            idx   <= '0;
                            state <= ST_BODY;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_BODY: begin
                    if (push && in_last) begin
                        idx   <= '0;
                        state <= ST_FOOTER;
                    end
                end
                ST_FOOTER: begin
                    if (push) begin
                        if (idx == 4'd7) begin
                            idx   <= '0;
                            state <= ST_FLUSH;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef QOI_FRAMER_BYTECOUNT_EN
    logic [31:0] byte_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            byte_count_q <= '0;
        end else if (pop) begin
            byte_count_q <= byte_count_q + 32'd1;
        end
    end

    assign byte_count = byte_count_q;
`else
    assign byte_count = 32'd0;
`endif

endmodule
